// File: rtl/fft_bitrev_reorder.sv
// Frame reorder: stores 64 samples in natural order to external RAM, reads back bit-reversed (FFT_REORDER_OVF_EN adds sticky OVF).
// Latency: first DOUT 66 ED cycles after first DI; BUSY from START to last DOUT, next START one cycle later.
// Backpressure: none; ED=0 freezes everything, START while BUSY is ignored.
module fft_bitrev_reorder #(
    parameter int nb = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ED,
    input  logic          START,
    input  logic [nb-1:0] DI,
    output logic [nb-1:0] DOUT,
    output logic          DOV,
    output logic          RDY,
    output logic          BUSY,
    output logic          OVF,
    output logic          RAM_ED,
    output logic          RAM_WE,
    output logic [5:0]    RAM_ADDR,
    output logic [nb-1:0] RAM_DI,
    input  logic [nb-1:0] RAM_DO
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t     state, state_nxt;
    logic [5:0] cnt, cnt_nxt;
    logic       rd_issue;
    logic       vld_p1;
    logic       first_p1;

    assign RAM_ED = ED;
    assign RAM_DI = DI;
    assign BUSY   = (state != IDLE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            cnt   <= 6'd0;
        end else if (ED) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        RAM_WE    = 1'b0;
        RAM_ADDR  = 6'd0;
        rd_issue  = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    state_nxt = WRITE;
                    cnt_nxt   = 6'd0;
                end
            end
            WRITE: begin
                RAM_WE   = 1'b1;
                RAM_ADDR = cnt;
                cnt_nxt  = cnt + 6'd1;
                if (cnt == 6'd63)
                    state_nxt = READ;
            end
            READ: begin
                RAM_ADDR = {cnt[0], cnt[1], cnt[2], cnt[3], cnt[4], cnt[5]};
                rd_issue = 1'b1;
                cnt_nxt  = cnt + 6'd1;
                if (cnt == 6'd63)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                // cnt restarts at 0 on entry; two cycles flush RAM and output stages
                cnt_nxt = cnt + 6'd1;
                if (cnt == 6'd1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 6'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 6'd0;
            end
        endcase
    end

    // Valid tag stage 1 lines up with RAM_DO, stage 2 is DOV itself
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            DOV      <= 1'b0;
            RDY      <= 1'b0;
            DOUT     <= '0;
        end else if (ED) begin
            vld_p1   <= rd_issue;
            first_p1 <= rd_issue && (cnt == 6'd0);
            DOV      <= vld_p1;
            RDY      <= first_p1;
            if (vld_p1)
                DOUT <= RAM_DO;
        end
    end

`ifdef FFT_REORDER_OVF_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            OVF <= 1'b0;
        else if (ED && START && BUSY)
            OVF <= 1'b1;
    end
`else
    assign OVF = 1'b0;
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder with a behavioural 64x32 synchronous RAM attached.
module tb_fft_bitrev_reorder;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ED;
    logic        START;
    logic [31:0] DI;
    logic [31:0] DOUT;
    logic        DOV;
    logic        RDY;
    logic        BUSY;
    logic        OVF;
    logic        RAM_ED;
    logic        RAM_WE;
    logic [5:0]  RAM_ADDR;
    logic [31:0] RAM_DI;
    logic [31:0] RAM_DO;

    int   total = 0;
    int   bad   = 0;
    logic ovf_sticky = 1'b0;

    logic [31:0] mem [64];

    fft_bitrev_reorder #(.nb(32)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .ED       (ED),
        .START    (START),
        .DI       (DI),
        .DOUT     (DOUT),
        .DOV      (DOV),
        .RDY      (RDY),
        .BUSY     (BUSY),
        .OVF      (OVF),
        .RAM_ED   (RAM_ED),
        .RAM_WE   (RAM_WE),
        .RAM_ADDR (RAM_ADDR),
        .RAM_DI   (RAM_DI),
        .RAM_DO   (RAM_DO)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RAM_ED) begin
            if (RAM_WE)
                mem[RAM_ADDR] <= RAM_DI;
            RAM_DO <= mem[RAM_ADDR];
        end
    end

    function automatic logic [5:0] brev(input logic [5:0] a);
        return {a[0], a[1], a[2], a[3], a[4], a[5]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected outputs while the frame is in ED cycle c (cycle 0 = START accepted)
    task automatic check_cycle(input int c, input int b);
        logic [5:0] ea;
        ea = 6'd0;
        if (c >= 1 && c <= 64)
            ea = 6'(c - 1);
        else if (c >= 65 && c <= 128)
            ea = brev(6'(c - 65));
        chk($sformatf("busy c%0d", c), 32'(BUSY), 32'(c >= 1 && c <= 130));
        chk($sformatf("dov c%0d", c), 32'(DOV), 32'(c >= 67 && c <= 130));
        chk($sformatf("rdy c%0d", c), 32'(RDY), 32'(c == 67));
        chk($sformatf("we c%0d", c), 32'(RAM_WE), 32'(c >= 1 && c <= 64));
        chk($sformatf("addr c%0d", c), 32'(RAM_ADDR), 32'(ea));
        chk($sformatf("ovf c%0d", c), 32'(OVF), 32'(ovf_sticky));
        if (c >= 67 && c <= 130)
            chk($sformatf("dout b%0d o%0d", b, c - 67), DOUT, 32'(b) + 32'(brev(6'(c - 67))));
    endtask

    task automatic edge_step(input logic e, input logic s, input logic [31:0] d);
        ED    = e;
        START = s;
        DI    = d;
        #1;
        chk("ram_ed", 32'(RAM_ED), 32'(e));
        chk("ram_di", RAM_DI, d);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic run_frame(input int b, input bit stalls, input int ovf_at, input int stop_at);
        for (int c = 0; c <= stop_at; c++) begin
            check_cycle(c, b);
            if (stalls && (c == 12 || c == 87)) begin
                for (int k = 0; k < ((c == 12) ? 3 : 5); k++) begin
                    edge_step(1'b0, 1'b0, 32'hBAD0_0000 + 32'(k));
                    check_cycle(c, b);
                end
            end
            if (c < stop_at || stop_at == 130)
                edge_step(1'b1, (c == 0) || (c == ovf_at),
                          (c >= 1 && c <= 64) ? 32'(b + c - 1) : 32'hDEAD_0000 + 32'(c));
`ifdef FFT_REORDER_OVF_EN
            if (c == ovf_at)
                ovf_sticky = 1'b1;
`endif
        end
    endtask

    task automatic check_reset_zero(input string tag);
        chk({tag, " dout"}, DOUT, 32'd0);
        chk({tag, " dov"}, 32'(DOV), 32'd0);
        chk({tag, " rdy"}, 32'(RDY), 32'd0);
        chk({tag, " busy"}, 32'(BUSY), 32'd0);
        chk({tag, " ovf"}, 32'(OVF), 32'd0);
        chk({tag, " we"}, 32'(RAM_WE), 32'd0);
        chk({tag, " addr"}, 32'(RAM_ADDR), 32'd0);
    endtask

    initial begin
        RST   = 1'b0;
        ED    = 1'b0;
        START = 1'b0;
        DI    = 32'd0;
        repeat (3) @(negedge CLK);
        check_reset_zero("por");
        RST = 1'b1;
        @(negedge CLK);

        // basic frame followed immediately by a back-to-back frame
        run_frame(0, 1'b0, -1, 130);
        run_frame(64, 1'b0, -1, 130);
        edge_step(1'b1, 1'b0, 32'd0);
        check_cycle(0, 0);

        // ED stalls during write and during output
        run_frame(200, 1'b1, -1, 130);

        // START during READ
        run_frame(300, 1'b0, 80, 130);
        edge_step(1'b1, 1'b0, 32'd0);
        check_cycle(0, 0);

        // reset in the middle of the write phase
        run_frame(500, 1'b0, -1, 31);
        RST = 1'b0;
        #1;
        ovf_sticky = 1'b0;
        check_reset_zero("rst_async");
        ED    = 1'b1;
        START = 1'b1;
        repeat (2) @(negedge CLK);
        check_reset_zero("rst_hold");
        START = 1'b0;
        RST   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            edge_step(1'b1, 1'b0, 32'd7);
            check_cycle(0, 0);
        end
        run_frame(100, 1'b0, -1, 130);
        check_cycle(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
